ddr3_app_resp: RTL and testbench

DDR3_APP_RESP -- requirements
Module: ddr3_app_resp

---
 rtl/ddr3_app_pkg.sv | 31 +++
 rtl/ddr3_app_fifo.sv | 47 ++++
 rtl/ddr3_app_resp.sv | 178 +++++++++++++++++
 tb/tb_ddr3_app_resp.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_app_pkg.sv
// Shared widths, command codes, executor state encoding and queue entry
// layouts for the DDR3 application-interface responder.
package ddr3_app_pkg;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 256;
    localparam int MASK_W = 32;
    localparam int CMD_W  = 3;

    localparam logic [CMD_W-1:0] CMD_WR = 3'b000;
    localparam logic [CMD_W-1:0] CMD_RD = 3'b001;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WR_WAIT  = 2'd1;
    localparam logic [1:0] ST_RD_ISSUE = 2'd2;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [ADDR_W-1:0] addr;
    } cmd_ent_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [MASK_W-1:0] mask;
    } wdf_ent_t;

    function automatic logic is_valid_cmd(input logic [CMD_W-1:0] cmd);
        return (cmd == CMD_WR) || (cmd == CMD_RD);
    endfunction

endpackage

// File: rtl/ddr3_app_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags.
// Push while full and pop while empty are ignored.
module ddr3_app_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/ddr3_app_resp.sv
// Behavioural DDR3 app-interface responder: calibration delay, command and
// write-data queues, in-order executor, byte-masked memory and read pipeline.
//
// state       | meaning
// ST_IDLE     | look at queue head; pop reads, hold writes at head
// ST_WR_WAIT  | write at head waits for a data beat, then pops both
// ST_RD_ISSUE | read memory word and launch it into the read pipeline
module ddr3_app_resp
    import ddr3_app_pkg::*;
#(
    parameter int MEM_AW    = 10,
    parameter int RD_LAT    = 8,
    parameter int CALIB_CYC = 64,
    parameter int Q_DEPTH   = 4
) (
    input  logic              ui_clk,
    input  logic              ui_rst,
    output logic              init_calib_complete,
    input  logic [ADDR_W-1:0] app_addr,
    input  logic [CMD_W-1:0]  app_cmd,
    input  logic              app_en,
    output logic              app_rdy,
    input  logic [DATA_W-1:0] app_wdf_data,
    input  logic [MASK_W-1:0] app_wdf_mask,
    input  logic              app_wdf_wren,
    input  logic              app_wdf_end,
    output logic              app_wdf_rdy,
    output logic [DATA_W-1:0] app_rd_data,
    output logic              app_rd_data_valid,
    output logic              proto_err
);

    localparam int CW = $clog2(CALIB_CYC + 1);

    logic [CW-1:0]     r_calib_cnt;
    logic              r_calib_done;
    logic              r_proto_err;
    logic [1:0]        r_state;
    logic [MEM_AW-1:0] r_rd_idx;
    logic [DATA_W-1:0] r_mem [2**MEM_AW];
    logic [RD_LAT-1:0] r_pipe_v;
    logic [DATA_W-1:0] r_pipe_d [RD_LAT];

    cmd_ent_t          w_cmd_din;
    cmd_ent_t          w_cmd_head;
    wdf_ent_t          w_wdf_din;
    wdf_ent_t          w_wdf_head;
    logic              w_cmd_full;
    logic              w_cmd_empty;
    logic              w_wdf_full;
    logic              w_wdf_empty;
    logic              w_cmd_acc;
    logic              w_cmd_push;
    logic              w_cmd_pop;
    logic              w_wdf_acc;
    logic              w_wr_exec;
    logic              w_rd_issue;
    logic              w_err_evt;
    logic [MEM_AW-1:0] w_head_idx;
    logic              w_unused_addr;

    assign init_calib_complete = r_calib_done;
    assign app_rdy             = r_calib_done && !w_cmd_full;
    assign app_wdf_rdy         = r_calib_done && !w_wdf_full;
    assign proto_err           = r_proto_err;

    assign w_cmd_acc  = app_en && app_rdy;
    assign w_cmd_push = w_cmd_acc && is_valid_cmd(app_cmd);
    assign w_wdf_acc  = app_wdf_wren && app_wdf_rdy;

    assign w_cmd_din.cmd   = app_cmd;
    assign w_cmd_din.addr  = app_addr;
    assign w_wdf_din.data  = app_wdf_data;
    assign w_wdf_din.mask  = app_wdf_mask;

    assign w_err_evt = (w_cmd_acc && (app_addr[2:0] != 3'b000)) ||
                       (w_cmd_acc && !is_valid_cmd(app_cmd)) ||
                       (w_wdf_acc && !app_wdf_end) ||
                       (r_calib_done && app_en && w_cmd_full) ||
                       (r_calib_done && app_wdf_wren && w_wdf_full);

    assign w_head_idx    = w_cmd_head.addr[MEM_AW+2:3];
    assign w_unused_addr = ^{w_cmd_head.addr[ADDR_W-1:MEM_AW+3], w_cmd_head.addr[2:0]};

    // Writes stay at the queue head until their data beat arrives, so the
    // command queue alone bounds outstanding unpaired writes.
    assign w_wr_exec  = (r_state == ST_WR_WAIT) && !w_wdf_empty;
    assign w_cmd_pop  = ((r_state == ST_IDLE) && !w_cmd_empty && (w_cmd_head.cmd == CMD_RD)) ||
                        w_wr_exec;
    assign w_rd_issue = (r_state == ST_RD_ISSUE);

    ddr3_app_fifo #(.WIDTH($bits(cmd_ent_t)), .DEPTH(Q_DEPTH)) u_cmd_q (
        .i_clk   (ui_clk),
        .i_rst   (ui_rst),
        .i_push  (w_cmd_push),
        .i_din   (w_cmd_din),
        .i_pop   (w_cmd_pop),
        .o_dout  (w_cmd_head),
        .o_full  (w_cmd_full),
        .o_empty (w_cmd_empty)
    );

    ddr3_app_fifo #(.WIDTH($bits(wdf_ent_t)), .DEPTH(Q_DEPTH)) u_wdf_q (
        .i_clk   (ui_clk),
        .i_rst   (ui_rst),
        .i_push  (w_wdf_acc),
        .i_din   (w_wdf_din),
        .i_pop   (w_wr_exec),
        .o_dout  (w_wdf_head),
        .o_full  (w_wdf_full),
        .o_empty (w_wdf_empty)
    );

    always_ff @(posedge ui_clk) begin
        if (ui_rst) begin
            r_calib_cnt  <= CW'(CALIB_CYC);
            r_calib_done <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            if (!r_calib_done) begin
                r_calib_cnt <= r_calib_cnt - CW'(1);
                if (r_calib_cnt == CW'(1)) r_calib_done <= 1'b1;
            end
            if (w_err_evt) r_proto_err <= 1'b1;
        end
    end

    always_ff @(posedge ui_clk) begin
        if (ui_rst) begin
            r_state  <= ST_IDLE;
            r_rd_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_cmd_empty) begin
                        if (w_cmd_head.cmd == CMD_RD) begin
                            r_state  <= ST_RD_ISSUE;
                            r_rd_idx <= w_head_idx;
                        end else begin
                            r_state <= ST_WR_WAIT;
                        end
                    end
                end
                ST_WR_WAIT:  if (!w_wdf_empty) r_state <= ST_IDLE;
                ST_RD_ISSUE: r_state <= ST_IDLE;
                default:     r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ui_clk) begin
        if (w_wr_exec) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (!w_wdf_head.mask[b]) r_mem[w_head_idx][8*b +: 8] <= w_wdf_head.data[8*b +: 8];
            end
        end
    end

    // Each stage loads data only with a valid token, so the last stage holds
    // the previous read word between pulses.
    always_ff @(posedge ui_clk) begin
        if (ui_rst) begin
            r_pipe_v <= '0;
            for (int i = 0; i < RD_LAT; i++) r_pipe_d[i] <= '0;
        end else begin
            r_pipe_v[0] <= w_rd_issue;
            if (w_rd_issue) r_pipe_d[0] <= r_mem[r_rd_idx];
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
                if (r_pipe_v[i-1]) r_pipe_d[i] <= r_pipe_d[i-1];
            end
        end
    end

    assign app_rd_data_valid = r_pipe_v[RD_LAT-1];
    assign app_rd_data       = r_pipe_d[RD_LAT-1];

endmodule

// File: tb/tb_ddr3_app_resp.sv
// Directed plus randomized bench for ddr3_app_resp, checked against an
// in-order memory model built from queues of pending commands and beats.
module tb_ddr3_app_resp;

    localparam int MEM_AW    = 10;
    localparam int RD_LAT    = 8;
    localparam int CALIB_CYC = 64;
    localparam int Q_DEPTH   = 4;

    logic         ui_clk;
    logic         ui_rst;
    logic         init_calib_complete;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [255:0] app_wdf_data;
    logic [31:0]  app_wdf_mask;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic         app_wdf_rdy;
    logic [255:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         proto_err;

    ddr3_app_resp #(
        .MEM_AW(MEM_AW), .RD_LAT(RD_LAT), .CALIB_CYC(CALIB_CYC), .Q_DEPTH(Q_DEPTH)
    ) dut (
        .ui_clk              (ui_clk),
        .ui_rst              (ui_rst),
        .init_calib_complete (init_calib_complete),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .proto_err           (proto_err)
    );

    initial ui_clk = 1'b0;
    always #5 ui_clk = ~ui_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_pulse = 0;
    int first_pulse_cyc = 0;
    logic [255:0] last_data;

    always @(posedge ui_clk) cyc = cyc + 1;

    // Reference model: memory plus in-order queues of commands and beats.
    logic [255:0] m_mem [1 << MEM_AW];
    int           mq_kind[$];
    int           mq_idx[$];
    logic [255:0] mq_bd[$];
    logic [31:0]  mq_bm[$];
    logic [255:0] q_exp[$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_resolve();
        logic [255:0] w;
        while (mq_kind.size() > 0) begin
            if (mq_kind[0] == 1) begin
                q_exp.push_back(m_mem[mq_idx[0]]);
                void'(mq_kind.pop_front());
                void'(mq_idx.pop_front());
            end else if (mq_bd.size() > 0) begin
                w = m_mem[mq_idx[0]];
                for (int b = 0; b < 32; b++)
                    if (!mq_bm[0][b]) w[8*b +: 8] = mq_bd[0][8*b +: 8];
                m_mem[mq_idx[0]] = w;
                void'(mq_kind.pop_front());
                void'(mq_idx.pop_front());
                void'(mq_bd.pop_front());
                void'(mq_bm.pop_front());
            end else begin
                break;
            end
        end
    endtask

    always @(negedge ui_clk) begin
        if (app_rd_data_valid) begin
            n_pulse++;
            last_data = app_rd_data;
            if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
            chk("pulse_expected", 256'(q_exp.size() != 0), 256'(1));
            if (q_exp.size() != 0) chk("rd_data", app_rd_data, q_exp.pop_front());
        end
    end

    task automatic send_cmd(input logic [2:0] c, input logic [27:0] a, output int acc_cyc);
        int n;
        n = 0;
        acc_cyc = 0;
        while (!app_rdy && n < 1000) begin
            @(negedge ui_clk);
            n++;
        end
        chk("cmd_rdy_wait", 256'(app_rdy), 256'(1));
        if (app_rdy) begin
            app_en = 1'b1; app_cmd = c; app_addr = a;
            acc_cyc = cyc;
            @(negedge ui_clk);
            app_en = 1'b0;
            if (c == 3'b000 || c == 3'b001) begin
                mq_kind.push_back((c == 3'b001) ? 1 : 0);
                mq_idx.push_back(int'(a[MEM_AW+2:3]));
                model_resolve();
            end
        end
    endtask

    task automatic send_beat(input logic [255:0] d, input logic [31:0] m, input logic e);
        int n;
        n = 0;
        while (!app_wdf_rdy && n < 1000) begin
            @(negedge ui_clk);
            n++;
        end
        chk("wdf_rdy_wait", 256'(app_wdf_rdy), 256'(1));
        if (app_wdf_rdy) begin
            app_wdf_wren = 1'b1; app_wdf_data = d; app_wdf_mask = m; app_wdf_end = e;
            @(negedge ui_clk);
            app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
            mq_bd.push_back(d);
            mq_bm.push_back(m);
            model_resolve();
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((q_exp.size() > 0 || mq_kind.size() > 0) && n < 3000) begin
            @(negedge ui_clk);
            n++;
        end
        chk(tag, 256'(q_exp.size() + mq_kind.size()), 256'(0));
    endtask

    task automatic do_reset(input bit full);
        @(negedge ui_clk);
        ui_rst = 1'b1; app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
        q_exp.delete(); mq_kind.delete(); mq_idx.delete(); mq_bd.delete(); mq_bm.delete();
        repeat (2) @(negedge ui_clk);
        if (full) begin
            chk("rst_calib", 256'(init_calib_complete), 256'(0));
            chk("rst_app_rdy", 256'(app_rdy), 256'(0));
            chk("rst_wdf_rdy", 256'(app_wdf_rdy), 256'(0));
            chk("rst_valid", 256'(app_rd_data_valid), 256'(0));
            chk("rst_proto", 256'(proto_err), 256'(0));
            chk("rst_rd_data", app_rd_data, 256'(0));
        end
        ui_rst = 1'b0;
        for (int k = 1; k <= CALIB_CYC; k++) begin
            @(negedge ui_clk);
            if (full && k == CALIB_CYC - 1) begin
                chk("calib_before", 256'(init_calib_complete), 256'(0));
                chk("rdy_before", 256'(app_rdy), 256'(0));
                chk("wdf_rdy_before", 256'(app_wdf_rdy), 256'(0));
            end
        end
        chk("calib_done", 256'(init_calib_complete), 256'(1));
        if (full) chk("rdy_at_calib", 256'(app_rdy), 256'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int a_first;
        int base;
        int idx;
        logic [31:0]  up;
        logic [255:0] d;
        logic [31:0]  m;

        ui_rst = 1'b1; app_en = 1'b0; app_cmd = 3'b000; app_addr = '0;
        app_wdf_wren = 1'b0; app_wdf_end = 1'b0; app_wdf_data = '0; app_wdf_mask = '0;
        do_reset(1'b1);

        // Sequential fill and in-order read-back with latency check.
        for (int i = 0; i < 16; i++) begin
            send_cmd(3'b000, 28'(i * 8), acc);
            send_beat(256'(i), 32'h0, 1'b1);
        end
        repeat (20) @(negedge ui_clk);
        base = n_pulse;
        first_pulse_cyc = -1;
        a_first = 0;
        for (int i = 0; i < 16; i++) begin
            send_cmd(3'b001, 28'(i * 8), acc);
            if (i == 0) a_first = acc;
        end
        wait_drain("seq_drain");
        chk("seq_pulses", 256'(n_pulse - base), 256'(16));
        chk("rd_latency", 256'(first_pulse_cyc - a_first), 256'(RD_LAT + 2));
        chk("seq_proto", 256'(proto_err), 256'(0));

        // Byte-mask merge.
        send_cmd(3'b000, 28'h0, acc);
        send_beat({256{1'b1}}, 32'h0, 1'b1);
        send_cmd(3'b000, 28'h0, acc);
        send_beat(256'h0, 32'hFFFF_0000, 1'b1);
        send_cmd(3'b001, 28'h0, acc);
        wait_drain("mask_drain");
        chk("mask_merge", last_data, {{128{1'b1}}, 128'h0});

        // Command queue backs up with no write data.
        for (int i = 0; i < 4; i++) send_cmd(3'b000, 28'((32 + i) * 8), acc);
        repeat (4) @(negedge ui_clk);
        chk("cmdq_full_rdy", 256'(app_rdy), 256'(0));
        for (int i = 0; i < 6; i++) send_beat(256'(32'hA000 + i), 32'h0, 1'b1);
        for (int i = 4; i < 6; i++) send_cmd(3'b000, 28'((32 + i) * 8), acc);
        for (int i = 0; i < 6; i++) send_cmd(3'b001, 28'((32 + i) * 8), acc);
        wait_drain("backup_drain");
        chk("backup_proto", 256'(proto_err), 256'(0));

        // Write data sent ahead of its commands.
        for (int i = 0; i < 3; i++) send_beat(256'(32'hB0B0_0000 + i), 32'h0000_00F0, 1'b1);
        for (int i = 0; i < 3; i++) send_cmd(3'b000, 28'((40 + i) * 8), acc);
        for (int i = 0; i < 3; i++) send_cmd(3'b001, 28'((40 + i) * 8), acc);
        wait_drain("ahead_drain");

        // Randomized mix over indices 0..15 with junk upper address bits.
        for (int i = 0; i < 40; i++) begin
            idx = int'($urandom_range(0, 15));
            up  = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                for (int j = 0; j < 8; j++) d[32*j +: 32] = $urandom;
                m = $urandom;
                send_cmd(3'b000, {up[14:0], 10'(idx), 3'b000}, acc);
                send_beat(d, m, 1'b1);
            end else begin
                send_cmd(3'b001, {up[14:0], 10'(idx), 3'b000}, acc);
            end
        end
        wait_drain("rand_drain");
        chk("rand_proto", 256'(proto_err), 256'(0));

        // Protocol errors.
        send_cmd(3'b001, 28'h4, acc);
        wait_drain("misalign_drain");
        chk("err_misalign", 256'(proto_err), 256'(1));
        do_reset(1'b0);
        chk("err_cleared", 256'(proto_err), 256'(0));

        base = n_pulse;
        send_cmd(3'b010, 28'h8, acc);
        repeat (2) @(negedge ui_clk);
        chk("err_badcmd", 256'(proto_err), 256'(1));
        send_cmd(3'b001, 28'h8, acc);
        wait_drain("badcmd_drain");
        repeat (RD_LAT + 4) @(negedge ui_clk);
        chk("badcmd_dropped", 256'(n_pulse - base), 256'(1));
        do_reset(1'b0);

        send_beat(256'h1234, 32'h0, 1'b0);
        @(negedge ui_clk);
        chk("err_wdf_end", 256'(proto_err), 256'(1));
        do_reset(1'b0);

        // Reset with reads in flight.
        base = n_pulse;
        for (int i = 0; i < 4; i++) send_cmd(3'b001, 28'(i * 8), acc);
        do_reset(1'b0);
        repeat (30) @(negedge ui_clk);
        chk("rst_no_pulses", 256'(n_pulse - base), 256'(0));
        chk("rst_proto_clear", 256'(proto_err), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
